mram_porta_arbiter: RTL

MRAM_PORTA_ARBITER -- requirements
Module: mram_porta_arbiter

---
 rtl/mram_arb_pkg.sv | 32 +++
 rtl/mram_arb_rr2.sv | 23 ++
 rtl/mram_porta_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mram_arb_pkg.sv
// mram_arb_pkg
//   Shared types and defaults for the MRAM Port A arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, own conv, own system)
//   - owner_e     : requester encoding. The value is also the bit index into
//                   the two-entry request/grant vectors of mram_arb_rr2.
//   - DEF_*       : default parameter values for the top level
package mram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_BURST  = 16;
    localparam int WE_WIDTH       = 4;
    // Cycles from a system read grant to its response.
    localparam int RD_STAGES      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_C = 2'd1,
        ST_OWN_S = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_C = 1'b0,
        OWNER_S = 1'b1
    } owner_e;

    // Requester that should be favoured after 'who' has been served.
    function automatic owner_e other_owner(input owner_e who);
        return (who == OWNER_C) ? OWNER_S : OWNER_C;
    endfunction

endpackage

// File: rtl/mram_arb_rr2.sv
// mram_arb_rr2
//   Two-way round-robin selector, purely combinational.
//   Ports:
//     req [1:0] : requests, index = owner_e (0 = conv, 1 = system)
//     ptr       : requester favoured when both request
//     gnt [1:0] : one-hot grant (all zero when no request)
module mram_arb_rr2
    import mram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     ptr,
    output logic [1:0] gnt
);

    logic fav_s;

    assign fav_s = (ptr == OWNER_S);

    // A requester wins if it is favoured or if the other one is idle.
    assign gnt[0] = req[0] & (~fav_s | ~req[1]);
    assign gnt[1] = req[1] & ( fav_s | ~req[0]);

endmodule

// File: rtl/mram_porta_arbiter.sv
// mram_porta_arbiter
//   Shares MRAM Port A between the conv engine (write-only) and the RISC-V
//   system port (read/write). Grants are combinational on the request cycle;
//   the granted beat is registered onto MRAM_PORTA_* one cycle later, and a
//   system read returns on s_rdata/s_rvalid two cycles after its grant.
//   A requester holding x_lock keeps the port for up to MAX_BURST beats.
//   Ports:
//     clk, reset                 : clock, async active-high reset
//     c_req/c_lock/c_addr/...    : conv engine beat request, c_gnt accept
//     s_req/s_lock/s_addr/...    : system beat request, s_gnt accept,
//                                  s_rdata/s_rvalid read response
//     MRAM_PORTA_en/addr/wdata/we: registered memory drive
//     MRAM_PORTA_rdata           : memory readback, one cycle after en
module mram_porta_arbiter
    import mram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  c_req,
    input  logic                  c_lock,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [WE_WIDTH-1:0]   c_we,
    output logic                  c_gnt,

    input  logic                  s_req,
    input  logic                  s_lock,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [WE_WIDTH-1:0]   s_we,
    output logic                  s_gnt,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rvalid,

    output logic                  MRAM_PORTA_en,
    output logic [ADDR_WIDTH-1:0] MRAM_PORTA_addr,
    output logic [DATA_WIDTH-1:0] MRAM_PORTA_wdata,
    output logic [WE_WIDTH-1:0]   MRAM_PORTA_we,
    input  logic [DATA_WIDTH-1:0] MRAM_PORTA_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e           state_q, state_d;
    owner_e               ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [1:0]           rr_req, rr_gnt;
    logic                 locked;
    logic                 rd_issue;
    logic [RD_STAGES:1]   rd_vld_pipe;

    // Ownership only excludes the other side while the owner keeps its lock
    // asserted. Once the lock drops, the same cycle is arbitrated normally so
    // the other requester can be served without an idle bubble.
    assign locked = ((state_q == ST_OWN_C) && c_lock) ||
                    ((state_q == ST_OWN_S) && s_lock);

    assign rr_req  = {s_req, c_req};
    assign cnt_inc = cnt_q + CNT_W'(1);

    mram_arb_rr2 u_rr (
        .req (rr_req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= OWNER_C;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        // Pointer always favours whoever was not served last, so leaving a
        // burst automatically hands priority to the other side.
        if (c_gnt)
            ptr_d = other_owner(OWNER_C);
        else if (s_gnt)
            ptr_d = other_owner(OWNER_S);

        if (locked) begin
            if (c_gnt || s_gnt) begin
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (c_gnt && c_lock) begin
                state_d = ST_OWN_C;
                cnt_d   = CNT_W'(1);
            end else if (s_gnt && s_lock) begin
                state_d = ST_OWN_S;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    // ---------------- grant outputs ----------------
    always_comb begin
        c_gnt = 1'b0;
        s_gnt = 1'b0;
        // Held low during reset so nothing is accepted while state is cleared.
        if (!reset) begin
            if (locked) begin
                c_gnt = (state_q == ST_OWN_C) && c_req;
                s_gnt = (state_q == ST_OWN_S) && s_req;
            end else begin
                c_gnt = rr_gnt[0];
                s_gnt = rr_gnt[1];
            end
        end
    end

    // ---------------- Port A drive and read tags ----------------
    assign rd_issue = s_gnt && (s_we == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MRAM_PORTA_en    <= 1'b0;
            MRAM_PORTA_addr  <= '0;
            MRAM_PORTA_wdata <= '0;
            MRAM_PORTA_we    <= '0;
            rd_vld_pipe      <= '0;
        end else begin
            MRAM_PORTA_en <= c_gnt || s_gnt;
            if (c_gnt) begin
                MRAM_PORTA_addr  <= c_addr;
                MRAM_PORTA_wdata <= c_wdata;
                MRAM_PORTA_we    <= c_we;
            end else if (s_gnt) begin
                MRAM_PORTA_addr  <= s_addr;
                MRAM_PORTA_wdata <= s_wdata;
                MRAM_PORTA_we    <= s_we;
            end else begin
                // addr/wdata hold to avoid toggling the macro inputs
                MRAM_PORTA_we    <= '0;
            end
            // Tag shift runs regardless of FSM state so reads in flight
            // complete across ownership changes.
            rd_vld_pipe <= {rd_vld_pipe[RD_STAGES-1:1], rd_issue};
        end
    end

    // Memory data is valid the cycle after en is sampled, which lines up
    // with the last tag stage; gate it so s_rdata is zero otherwise.
    assign s_rvalid = rd_vld_pipe[RD_STAGES];
    assign s_rdata  = s_rvalid ? MRAM_PORTA_rdata : '0;

endmodule
